// File: rtl/sensor_frame_tx.sv
// Framing stage: buffers one binary record from the command stream and emits it to the UART
// as an ASCII-hex line ':' LL DD..DD CC CR LF with a two's-complement checksum.
module sensor_frame_tx #(
    parameter int unsigned MAX_LEN  = 8,
    parameter logic [7:0]  SOF_CHAR = 8'h3A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       busy,
    output logic       overflow_err
);

    localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        StIdle,
        StCapture,
        StDiscard,
        StSof,
        StLenHi,
        StLenLo,
        StDatHi,
        StDatLo,
        StCkHi,
        StCkLo,
        StCr,
        StLf
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] sum_q;
    logic [7:0] idx_q;
    logic       dropped_q;
    logic [7:0] buf_mem [MAX_LEN];

    logic       in_capture;
    logic       accept;
    logic       m_fire;
    logic [7:0] ck;
    logic [7:0] idx_nxt;
    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        in_capture   = (state_q == StIdle) || (state_q == StCapture);
        // Gate with rst so the input side stalls for the whole reset pulse.
        s_tready     = !rst && (in_capture || (state_q == StDiscard));
        accept       = s_tvalid && s_tready;
        m_fire       = m_tvalid && m_tready;
        overflow_err = accept && (state_q == StDiscard) && !dropped_q;
        // Length byte is part of the checksummed bytes, so LL..CC sums to zero.
        ck           = 8'h00 - (cnt_q + sum_q);
        idx_nxt      = idx_q + 8'd1;
        cur_byte     = buf_mem[idx_q[IdxW-1:0]];
        nxt_byte     = buf_mem[idx_nxt[IdxW-1:0]];
    end

    // Payload storage carries no reset; stale contents are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (accept && in_capture) begin
            buf_mem[cnt_q[IdxW-1:0]] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'h00;
            sum_q     <= 8'h00;
            idx_q     <= 8'h00;
            dropped_q <= 1'b0;
            m_tdata   <= 8'h00;
            m_tvalid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StCapture: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 8'd1;
                        sum_q <= sum_q + s_tdata;
                        busy  <= 1'b1;
                        if (s_tlast) begin
                            state_q  <= StSof;
                            m_tvalid <= 1'b1;
                            m_tdata  <= SOF_CHAR;
                        end else if (cnt_q + 8'd1 == MaxLen) begin
                            state_q   <= StDiscard;
                            dropped_q <= 1'b0;
                        end else begin
                            state_q <= StCapture;
                        end
                    end
                end
                StDiscard: begin
                    if (accept) begin
                        dropped_q <= 1'b1;
                        if (s_tlast) begin
                            state_q  <= StSof;
                            m_tvalid <= 1'b1;
                            m_tdata  <= SOF_CHAR;
                        end
                    end
                end
                StSof: begin
                    if (m_fire) begin
                        state_q <= StLenHi;
                        m_tdata <= hex_char(cnt_q[7:4]);
                    end
                end
                StLenHi: begin
                    if (m_fire) begin
                        state_q <= StLenLo;
                        m_tdata <= hex_char(cnt_q[3:0]);
                    end
                end
                StLenLo: begin
                    if (m_fire) begin
                        state_q <= StDatHi;
                        m_tdata <= hex_char(cur_byte[7:4]);
                    end
                end
                StDatHi: begin
                    if (m_fire) begin
                        state_q <= StDatLo;
                        m_tdata <= hex_char(cur_byte[3:0]);
                    end
                end
                StDatLo: begin
                    if (m_fire) begin
                        if (idx_nxt == cnt_q) begin
                            state_q <= StCkHi;
                            m_tdata <= hex_char(ck[7:4]);
                        end else begin
                            idx_q   <= idx_nxt;
                            state_q <= StDatHi;
                            m_tdata <= hex_char(nxt_byte[7:4]);
                        end
                    end
                end
                StCkHi: begin
                    if (m_fire) begin
                        state_q <= StCkLo;
                        m_tdata <= hex_char(ck[3:0]);
                    end
                end
                StCkLo: begin
                    if (m_fire) begin
                        state_q <= StCr;
                        m_tdata <= 8'h0D;
                    end
                end
                StCr: begin
                    if (m_fire) begin
                        state_q <= StLf;
                        m_tdata <= 8'h0A;
                    end
                end
                StLf: begin
                    if (m_fire) begin
                        state_q  <= StIdle;
                        m_tvalid <= 1'b0;
                        busy     <= 1'b0;
                        cnt_q    <= 8'h00;
                        sum_q    <= 8'h00;
                        idx_q    <= 8'h00;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
